// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_rx_pkg;

    // Default counter widths.
    localparam int unsigned DEFAULT_PRESCALE_W = 6;
    localparam int unsigned DEFAULT_BIT_CNT_W  = 4;

    // Oversampling ratios.
    localparam int unsigned MIN_PRESCALE = 8;
    localparam int unsigned PRESCALE_X8  = 8;
    localparam int unsigned PRESCALE_X16 = 16;
    localparam int unsigned PRESCALE_X32 = 32;

    // Frame lengths in bits, start and stop included; shared with the RX FSM.
    localparam int unsigned FRAME_BITS_PAR   = 11;
    localparam int unsigned FRAME_BITS_NOPAR = 10;

    // Two-out-of-three majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler_edge_bit_counter.sv
// Oversampling edge counter, bit counter and the latched prescale.
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W,
    parameter int unsigned BIT_CNT_W  = DEFAULT_BIT_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] period,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_done
);

    localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(MIN_PRESCALE);
    localparam logic [BIT_CNT_W-1:0]  B_ONE = BIT_CNT_W'(1);

    logic [PRESCALE_W-1:0] p_load;
    logic                  last_edge;

    // Sanitize the requested ratio: clamp to the minimum and force it even.
    always_comb begin
        p_load = {prescale[PRESCALE_W-1:1], 1'b0};
        if (prescale < P_MIN) begin
            p_load = P_MIN;
        end
    end

    assign last_edge = (edge_cnt == (period - P_ONE));

    // End-of-bit flag, only meaningful while the counters run.
    assign bit_done = enable & last_edge;

    // Prescale tracks the input while idle; counters run only while enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            period   <= P_MIN;
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!enable) begin
            period   <= p_load;
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (last_edge) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + B_ONE;
        end else begin
            edge_cnt <= edge_cnt + P_ONE;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX oversampling front end: three mid-bit samples and a majority vote.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W,
    parameter int unsigned BIT_CNT_W  = DEFAULT_BIT_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  enable,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_done
);

    localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] period;
    logic [PRESCALE_W-1:0] half;
    logic                  s0;
    logic                  s1;

    edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_edge_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .prescale (Prescale),
        .period   (period),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done)
    );

    // Mid-bit reference point; the latched period is always even.
    assign half = period >> 1;

    // Capture samples at H-1 and H, vote with the live line at H+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (enable) begin
                if (edge_cnt == (half - P_ONE)) begin
                    s0 <= RX_IN;
                end
                if (edge_cnt == half) begin
                    s1 <= RX_IN;
                end
                if (edge_cnt == (half + P_ONE)) begin
                    sampled_bit  <= maj3(s0, s1, RX_IN);
                    sample_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: per-cycle vector table plus
// hand-written sequences for frames, prescale latching, abort and reset.
module tb_uart_rx_sampler;

    logic       clk;
    logic       reset;
    logic       rx_in;
    logic [5:0] prescale;
    logic       enable;
    logic       sampled_bit;
    logic       sample_valid;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       bit_done;

    int checks;
    int errors;

    uart_rx_sampler dut (
        .clk          (clk),
        .reset        (reset),
        .RX_IN        (rx_in),
        .Prescale     (prescale),
        .enable       (enable),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .bit_done     (bit_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       rx;
        logic [5:0] pre;
        int         e;
        int         b;
        logic       v;
        logic       sb;
        logic       d;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic rx, input logic [5:0] pre,
                       input int e, input int b, input logic v, input logic sb, input logic d);
        vec_t t;
        t.rst = rst; t.en = en; t.rx = rx; t.pre = pre;
        t.e = e; t.b = b; t.v = v; t.sb = sb; t.d = d;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic rx, input logic [5:0] pre);
        reset    = rst;
        enable   = en;
        rx_in    = rx;
        prescale = pre;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n enabled edges at a fixed line level, recording strobe/done activity.
    task automatic run_en(input int n, input logic rx_v,
                          output int first_v, output int n_v, output int n_d);
        first_v = -1;
        n_v     = 0;
        n_d     = 0;
        for (int k = 1; k <= n; k++) begin
            enable = 1'b1;
            rx_in  = rx_v;
            tick();
            if (sample_valid) begin
                if (first_v < 0) first_v = k;
                n_v++;
            end
            if (bit_done) n_d++;
        end
    endtask

    initial begin
        int          fv, nv, nd;
        int          ns, ndone;
        logic [9:0]  frame;
        logic        bitv;
        string       nm;

        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 1'b0, 6'd8);

        // Reset with RX low, then P=8 run; bit2 has one glitch low, bit3 two lows.
        //  rst en rx pre   edge bit v  sb d
        add(1, 0, 0, 8,   0, 0, 0, 1, 0);
        add(0, 1, 0, 8,   1, 0, 0, 1, 0);
        add(0, 1, 0, 8,   2, 0, 0, 1, 0);
        add(0, 1, 0, 8,   3, 0, 0, 1, 0);
        add(0, 1, 0, 8,   4, 0, 0, 1, 0);
        add(0, 1, 0, 8,   5, 0, 0, 1, 0);
        add(0, 1, 0, 8,   6, 0, 1, 0, 0);
        add(0, 1, 0, 8,   7, 0, 0, 0, 1);
        add(0, 1, 0, 8,   0, 1, 0, 0, 0);
        add(0, 1, 0, 8,   1, 1, 0, 0, 0);
        add(0, 1, 0, 8,   2, 1, 0, 0, 0);
        add(0, 1, 0, 8,   3, 1, 0, 0, 0);
        add(0, 1, 0, 8,   4, 1, 0, 0, 0);
        add(0, 1, 0, 8,   5, 1, 0, 0, 0);
        add(0, 1, 0, 8,   6, 1, 1, 0, 0);
        add(0, 1, 0, 8,   7, 1, 0, 0, 1);
        add(0, 1, 0, 8,   0, 2, 0, 0, 0);
        add(0, 1, 1, 8,   1, 2, 0, 0, 0);
        add(0, 1, 1, 8,   2, 2, 0, 0, 0);
        add(0, 1, 1, 8,   3, 2, 0, 0, 0);
        add(0, 1, 1, 8,   4, 2, 0, 0, 0);
        add(0, 1, 0, 8,   5, 2, 0, 0, 0);
        add(0, 1, 1, 8,   6, 2, 1, 1, 0);
        add(0, 1, 1, 8,   7, 2, 0, 1, 1);
        add(0, 1, 1, 8,   0, 3, 0, 1, 0);
        add(0, 1, 1, 8,   1, 3, 0, 1, 0);
        add(0, 1, 1, 8,   2, 3, 0, 1, 0);
        add(0, 1, 1, 8,   3, 3, 0, 1, 0);
        add(0, 1, 0, 8,   4, 3, 0, 1, 0);
        add(0, 1, 0, 8,   5, 3, 0, 1, 0);
        add(0, 1, 1, 8,   6, 3, 1, 0, 0);
        add(0, 1, 1, 8,   7, 3, 0, 0, 1);
        add(0, 1, 1, 8,   0, 4, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].rx, vecs[i].pre);
            tick();
            nm = $sformatf("vec%0d", i);
            check({nm, ".edge_cnt"},     int'(edge_cnt),     vecs[i].e);
            check({nm, ".bit_cnt"},      int'(bit_cnt),      vecs[i].b);
            check({nm, ".sample_valid"}, int'(sample_valid), int'(vecs[i].v));
            check({nm, ".sampled_bit"},  int'(sampled_bit),  int'(vecs[i].sb));
            check({nm, ".bit_done"},     int'(bit_done),     int'(vecs[i].d));
        end

        // P=16 frame 0x55, no parity: start, data LSB first, stop.
        drive(1'b0, 1'b0, 1'b1, 6'd16);
        tick();
        check("a.idle_edge", int'(edge_cnt), 0);
        frame = {1'b1, 8'h55, 1'b0};
        ns    = 0;
        ndone = 0;
        for (int k = 0; k < 160; k++) begin
            enable = 1'b1;
            rx_in  = frame[k / 16];
            tick();
            if (sample_valid) begin
                if (ns < 10) begin
                    bitv = frame[ns];
                    check($sformatf("a.strobe%0d.value", ns), int'(sampled_bit), int'(bitv));
                    check($sformatf("a.strobe%0d.edge", ns), int'(edge_cnt), 10);
                    check($sformatf("a.strobe%0d.bit_cnt", ns), int'(bit_cnt), ns);
                end
                ns++;
            end
            if (bit_done) ndone++;
        end
        check("a.strobes", ns, 10);
        check("a.bit_done_pulses", ndone, 10);

        // Prescale change mid-frame is ignored until enable drops.
        drive(1'b0, 1'b0, 1'b1, 6'd8);
        tick();
        run_en(3, 1'b1, fv, nv, nd);
        check("b.pre_strobes", nv, 0);
        prescale = 6'd32;
        run_en(13, 1'b1, fv, nv, nd);
        check("b.mid_first", fv, 3);
        check("b.mid_strobes", nv, 2);
        check("b.mid_done", nd, 2);
        check("b.mid_edge", int'(edge_cnt), 0);
        check("b.mid_bit", int'(bit_cnt), 2);
        enable = 1'b0;
        tick();
        check("b.off_edge", int'(edge_cnt), 0);
        check("b.off_bit", int'(bit_cnt), 0);
        run_en(32, 1'b0, fv, nv, nd);
        check("b.p32_first", fv, 18);
        check("b.p32_strobes", nv, 1);
        check("b.p32_done", nd, 1);
        check("b.p32_edge", int'(edge_cnt), 0);
        check("b.p32_bit", int'(bit_cnt), 1);
        check("b.p32_value", int'(sampled_bit), 0);
        drive(1'b0, 1'b0, 1'b1, 6'd5);
        tick();
        run_en(8, 1'b1, fv, nv, nd);
        check("b.p5_first", fv, 6);
        check("b.p5_strobes", nv, 1);
        check("b.p5_done", nd, 1);
        check("b.p5_bit", int'(bit_cnt), 1);
        check("b.p5_value", int'(sampled_bit), 1);

        // Abort a bit at edge 4: no strobe, value held, counters restart.
        drive(1'b0, 1'b0, 1'b1, 6'd8);
        tick();
        run_en(8, 1'b0, fv, nv, nd);
        check("c.first_value", int'(sampled_bit), 0);
        run_en(4, 1'b1, fv, nv, nd);
        check("c.partial_strobes", nv, 0);
        check("c.partial_edge", int'(edge_cnt), 4);
        enable = 1'b0;
        tick();
        check("c.abort_edge", int'(edge_cnt), 0);
        check("c.abort_bit", int'(bit_cnt), 0);
        check("c.abort_valid", int'(sample_valid), 0);
        check("c.abort_hold", int'(sampled_bit), 0);
        check("c.abort_done", int'(bit_done), 0);
        tick();
        check("c.idle_valid", int'(sample_valid), 0);
        run_en(5, 1'b1, fv, nv, nd);
        check("c.restart_strobes", nv, 0);
        check("c.restart_edge", int'(edge_cnt), 5);
        check("c.restart_hold", int'(sampled_bit), 0);
        run_en(1, 1'b1, fv, nv, nd);
        check("c.restart_strobe", nv, 1);
        check("c.restart_value", int'(sampled_bit), 1);

        // Reset at edge 5 while enabled wins over the pending strobe.
        drive(1'b0, 1'b0, 1'b0, 6'd8);
        tick();
        run_en(8, 1'b0, fv, nv, nd);
        check("d.pre_value", int'(sampled_bit), 0);
        run_en(5, 1'b0, fv, nv, nd);
        check("d.pre_edge", int'(edge_cnt), 5);
        drive(1'b1, 1'b1, 1'b0, 6'd8);
        tick();
        check("d.rst_edge", int'(edge_cnt), 0);
        check("d.rst_bit", int'(bit_cnt), 0);
        check("d.rst_valid", int'(sample_valid), 0);
        check("d.rst_value", int'(sampled_bit), 1);
        check("d.rst_done", int'(bit_done), 0);
        reset = 1'b0;
        tick();
        check("d.post_edge", int'(edge_cnt), 1);
        check("d.post_valid", int'(sample_valid), 0);
        run_en(5, 1'b0, fv, nv, nd);
        check("d.post_first", fv, 5);
        check("d.post_value", int'(sampled_bit), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling front end of the UART receiver: counts oversampling edges and bit periods, takes three mid-bit samples of the synchronized serial line, and produces a majority-voted `sampled_bit` with a one-cycle valid strobe. It sits between the RX input synchronizer and the RX control FSM. Its outputs feed the start, data-deserializer, parity-check and stop-check stages. The RX FSM gates it with `enable` and uses `edge_cnt`, `bit_cnt` and `bit_done` to sequence the frame.

## Interface
- `PRESCALE_W`, default 6: width of the prescale and edge counter. Supports oversampling ratios up to 32.
- `BIT_CNT_W`, default 4: width of the bit counter. Covers start, 8 data, parity and stop bits.
- `clk`  in  1  receiver clock (oversampling clock).
- `reset`  in  1  synchronous, active-high reset.
- `RX_IN`  in  1  serial line. It is already synchronized to `clk` upstream; idle level is 1.
- `Prescale`  in  PRESCALE_W  oversampling ratio. Legal values are 8, 16 and 32.
- `enable`  in  1  from the RX FSM. High means the counters run and sampling is active.
- `sampled_bit`  out  1  majority vote of the three mid-bit samples.
- `sample_valid`  out  1  one-cycle strobe: `sampled_bit` was updated this cycle.
- `edge_cnt`  out  PRESCALE_W  oversampling edge index within the current bit, from 0 to P-1.
- `bit_cnt`  out  BIT_CNT_W  bit index within the frame (start bit = 0).
- `bit_done`  out  1  one-cycle pulse in the cycle where `edge_cnt == P-1`.

## Operation
- **Prescale latch:** P is an internal register.
  - P loads `Prescale` on every clock while `enable` is low.
  - P is frozen while `enable` is high, so mid-frame changes to `Prescale` are ignored.
  - A `Prescale` value below 8 loads as 8. An odd value has its LSB cleared.
- **Edge counter:** while `enable` is high, `edge_cnt` increments every clock. At P-1 it wraps to 0 on the next clock.
- **Bit counter:** `bit_cnt` increments on each `edge_cnt` wrap. At 2^BIT_CNT_W-1 it wraps to 0; the FSM must drop `enable` before that.
- **Sample points:** with H = P/2, `RX_IN` is captured into s0 at `edge_cnt == H-1` and into s1 at `edge_cnt == H`.
- **Vote:** on the clock edge where `edge_cnt == H+1`, `sampled_bit` <= maj(s0, s1, RX_IN) and `sample_valid` <= 1. `sample_valid` is 0 on all other cycles.
- **Disable:** when `enable` is low, on the next clock:
  - `edge_cnt` and `bit_cnt` go to 0, and `bit_done` and `sample_valid` go to 0.
  - `sampled_bit` holds its value. s0 and s1 hold their values but are unused until refilled.
- **Disable mid-bit:** dropping `enable` mid-bit aborts that bit with no strobe. Re-asserting `enable` restarts at `edge_cnt = 0`, `bit_cnt = 0`.
- **Reset:** `edge_cnt` = 0, `bit_cnt` = 0, `sampled_bit` = 1, `sample_valid` = 0, `bit_done` = 0, s0 = s1 = 1, P = 8. Reset overrides `enable` in the same cycle.

## Timing
- The first rising clock with `enable` high moves `edge_cnt` from 0 to 1. The cycle in which `enable` first reads high counts as edge 0.
- `sample_valid` is high in the cycle where `edge_cnt == H+2`. That cycle is:
  - edge 6 for P=8,
  - edge 10 for P=16,
  - edge 18 for P=32.
- Latency from the third sample to the strobe is 1 cycle.
- `sampled_bit` stays stable until the next strobe. Downstream stages (parity check, deserializer) consume it while `sample_valid` is high, or any time before the next strobe.
- `bit_done` is combinational from registered state: high exactly while `edge_cnt == P-1` and `enable` is high. `bit_cnt` changes on the following edge.
- All outputs are registered except `bit_done`.
- Throughput: one bit every P cycles.
- No backpressure: downstream must accept each strobe.

## Structure
- Shared package `uart_rx_pkg` holds:
  - `MIN_PRESCALE = 8`,
  - the legal prescale constants (8/16/32),
  - the default `BIT_CNT_W` and `PRESCALE_W`,
  - the frame-length constants shared with the RX FSM (`FRAME_BITS_PAR = 11`, `FRAME_BITS_NOPAR = 10`).
- One sub-module, `edge_bit_counter`, holds the P latch, `edge_cnt`, `bit_cnt` and `bit_done`. The sampling registers and the majority voter stay in the top level.

## Test plan
- Reset with `RX_IN = 0` -> `sampled_bit = 1`, `sample_valid = 0`, both counters 0; then `enable` high, P=8 -> `sample_valid` pulses at edges 6, 14, 22, … of the enabled run, and `sampled_bit = 0`.
- P=16, frame 0x55 LSB first with no parity: drive each bit for 16 cycles -> 10 strobes with values 0,1,0,1,0,1,0,1,0,1 and `bit_cnt` reaching 9; `bit_done` pulses 10 times.
- Glitch rejection, P=8: the bit is 1 but `RX_IN = 0` only at edge 4 -> `sampled_bit = 1`. Same with two of the three samples at 0 -> `sampled_bit = 0`.
- Change `Prescale` from 8 to 32 mid-frame with `enable` high -> period stays 8; after `enable` low then high, the period becomes 32 and the first strobe is at edge 18. `Prescale = 5` -> behaves as 8.
- Drop `enable` at `edge_cnt = 4`, then reassert -> counters restart at 0, no strobe for the aborted bit, `sampled_bit` holds its prior value.
- Assert `reset` at `edge_cnt = 5` with `enable` high -> all outputs take their reset values on the next clock, and no strobe occurs.
